// File: rtl/rsp_s1_prep_ahbic_in_hold.sv
`default_nettype none
// ============================================================================
// Module   : rsp_s1_prep_ahbic_in_hold
// Purpose  : AHB interconnect input stage. Address phases from one master
//            port pass straight through to the output stage when it is free.
//            When it is busy, the address phase is captured in a holding
//            register and the master is stalled until the output stage
//            grants the port, at which point the held transfer is replayed.
//            The slave's data-phase ready, response and read data are
//            returned to the master.
// Ports    : HCLK, HRESET (sync, active-high)
//            Master side : HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS,
//                          HPROTS, HMASTERS, HMASTLOCKS, HREADYS, HWDATAS in;
//                          HREADYOUTS, HRESPS, HRDATAS out
//            Output stage: *_op address/control, wdata_op, held_tran_op out;
//                          active_op, HREADYMUXM, HRESPM, HRDATAM in
// Revision : 1.0 - initial release
// ============================================================================
module rsp_s1_prep_ahbic_in_hold (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSELS,
    input  logic [31:0] HADDRS,
    input  logic [1:0]  HTRANSS,
    input  logic        HWRITES,
    input  logic [2:0]  HSIZES,
    input  logic [2:0]  HBURSTS,
    input  logic [3:0]  HPROTS,
    input  logic [3:0]  HMASTERS,
    input  logic        HMASTLOCKS,
    input  logic        HREADYS,
    input  logic [31:0] HWDATAS,
    output logic        HREADYOUTS,
    output logic        HRESPS,
    output logic [31:0] HRDATAS,
    output logic        sel_op,
    output logic [31:0] addr_op,
    output logic [1:0]  trans_op,
    output logic        write_op,
    output logic [2:0]  size_op,
    output logic [2:0]  burst_op,
    output logic [3:0]  prot_op,
    output logic [3:0]  master_op,
    output logic        mastlock_op,
    output logic [31:0] wdata_op,
    output logic        held_tran_op,
    input  logic        active_op,
    input  logic        HREADYMUXM,
    input  logic        HRESPM,
    input  logic [31:0] HRDATAM
);

    localparam logic [1:0] S_IDLE = 2'd0;   // no transfer pending
    localparam logic [1:0] S_WAIT = 2'd1;   // held transfer waiting for grant
    localparam logic [1:0] S_DATA = 2'd2;   // data phase outstanding

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_held_vld;
    logic        w_capture;
    logic        w_release;
    logic        w_accept;
    logic        w_issue;
    logic        w_hreadyout;
    logic        w_hresp;

    logic        r_hold_sel;
    logic [31:0] r_hold_addr;
    logic [1:0]  r_hold_trans;
    logic        r_hold_write;
    logic [2:0]  r_hold_size;
    logic [2:0]  r_hold_burst;
    logic [3:0]  r_hold_prot;
    logic [3:0]  r_hold_master;
    logic        r_hold_mastlock;

    // Only NONSEQ/SEQ count; IDLE and BUSY never reach the output stage.
    assign w_accept     = HSELS & HREADYS & HTRANSS[1];
    assign held_tran_op = r_held_vld | w_accept;
    assign w_issue      = held_tran_op & active_op & HREADYMUXM;

    // ------------------------------------------------------------------
    // State register and holding-register valid bit
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= S_IDLE;
            r_held_vld <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_held_vld <= 1'b1;
            end else if (w_release) begin
                r_held_vld <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and master-side response
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        w_hreadyout = 1'b1;
        w_hresp     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_issue) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Master stalled; live inputs are irrelevant until the
                // held transfer is granted.
                w_hreadyout = 1'b0;
                if (w_issue) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_hreadyout = HREADYMUXM;
                w_hresp     = HRESPM;
                // Data phase ends this cycle: the pipelined next address is
                // evaluated in the same edge so back-to-back beats see no
                // bubble.
                if (HREADYMUXM) begin
                    if (!w_accept) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_issue) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register (address phase captured when the output stage is busy)
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_hold_sel      <= 1'b0;
            r_hold_addr     <= 32'h0;
            r_hold_trans    <= 2'b00;
            r_hold_write    <= 1'b0;
            r_hold_size     <= 3'b000;
            r_hold_burst    <= 3'b000;
            r_hold_prot     <= 4'h0;
            r_hold_master   <= 4'h0;
            r_hold_mastlock <= 1'b0;
        end else if (w_capture) begin
            r_hold_sel      <= HSELS;
            r_hold_addr     <= HADDRS;
            r_hold_trans    <= HTRANSS;
            r_hold_write    <= HWRITES;
            r_hold_size     <= HSIZES;
            r_hold_burst    <= HBURSTS;
            r_hold_prot     <= HPROTS;
            r_hold_master   <= HMASTERS;
            r_hold_mastlock <= HMASTLOCKS;
        end
    end

    // ------------------------------------------------------------------
    // Output stage mux: held transfer wins while valid, else live inputs
    // ------------------------------------------------------------------
    assign sel_op      = r_held_vld ? r_hold_sel      : HSELS;
    assign addr_op     = r_held_vld ? r_hold_addr     : HADDRS;
    assign trans_op    = r_held_vld ? r_hold_trans    : HTRANSS;
    assign write_op    = r_held_vld ? r_hold_write    : HWRITES;
    assign size_op     = r_held_vld ? r_hold_size     : HSIZES;
    assign burst_op    = r_held_vld ? r_hold_burst    : HBURSTS;
    assign prot_op     = r_held_vld ? r_hold_prot     : HPROTS;
    assign master_op   = r_held_vld ? r_hold_master   : HMASTERS;
    assign mastlock_op = r_held_vld ? r_hold_mastlock : HMASTLOCKS;
    assign wdata_op    = HWDATAS;

    assign HREADYOUTS  = w_hreadyout;
    assign HRESPS      = w_hresp;
    assign HRDATAS     = HRDATAM;

endmodule
`default_nettype wire

// File: tb/tb_rsp_s1_prep_ahbic_in_hold.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsp_s1_prep_ahbic_in_hold
// Purpose  : Self-checking bench for rsp_s1_prep_ahbic_in_hold. Directed
//            scenarios followed by randomized traffic checked against a
//            transfer-level reference model and an in-order issue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsp_s1_prep_ahbic_in_hold;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic [3:0]  HMASTERS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic [31:0] HWDATAS;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic [31:0] HRDATAS;
    logic        sel_op;
    logic [31:0] addr_op;
    logic [1:0]  trans_op;
    logic        write_op;
    logic [2:0]  size_op;
    logic [2:0]  burst_op;
    logic [3:0]  prot_op;
    logic [3:0]  master_op;
    logic        mastlock_op;
    logic [31:0] wdata_op;
    logic        held_tran_op;
    logic        active_op;
    logic        HREADYMUXM;
    logic        HRESPM;
    logic [31:0] HRDATAM;

    int n_cmp = 0;
    int n_err = 0;

    // Address phase as seen on the bus (sel, addr, trans, write, size,
    // burst, prot, master, lock).
    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [3:0]  master;
        logic        lock;
    } ap_t;

    always #5 HCLK = ~HCLK;

    // Single master on the system bus: its HREADY is this port's HREADYOUT.
    assign HREADYS = HREADYOUTS;

    rsp_s1_prep_ahbic_in_hold u_dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HSELS        (HSELS),
        .HADDRS       (HADDRS),
        .HTRANSS      (HTRANSS),
        .HWRITES      (HWRITES),
        .HSIZES       (HSIZES),
        .HBURSTS      (HBURSTS),
        .HPROTS       (HPROTS),
        .HMASTERS     (HMASTERS),
        .HMASTLOCKS   (HMASTLOCKS),
        .HREADYS      (HREADYS),
        .HWDATAS      (HWDATAS),
        .HREADYOUTS   (HREADYOUTS),
        .HRESPS       (HRESPS),
        .HRDATAS      (HRDATAS),
        .sel_op       (sel_op),
        .addr_op      (addr_op),
        .trans_op     (trans_op),
        .write_op     (write_op),
        .size_op      (size_op),
        .burst_op     (burst_op),
        .prot_op      (prot_op),
        .master_op    (master_op),
        .mastlock_op  (mastlock_op),
        .wdata_op     (wdata_op),
        .held_tran_op (held_tran_op),
        .active_op    (active_op),
        .HREADYMUXM   (HREADYMUXM),
        .HRESPM       (HRESPM),
        .HRDATAM      (HRDATAM)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        HSELS      = 1'b0;
        HADDRS     = 32'h0;
        HTRANSS    = 2'b00;
        HWRITES    = 1'b0;
        HSIZES     = 3'd2;
        HBURSTS    = 3'd0;
        HPROTS     = 4'h3;
        HMASTERS   = 4'h1;
        HMASTLOCKS = 1'b0;
    endtask

    task automatic bus_addr(input logic [1:0] trans, input logic [31:0] addr,
                            input logic wr, input logic [2:0] burst, input logic lock);
        HSELS      = 1'b1;
        HADDRS     = addr;
        HTRANSS    = trans;
        HWRITES    = wr;
        HSIZES     = 3'd2;
        HBURSTS    = burst;
        HPROTS     = 4'h3;
        HMASTERS   = 4'h1;
        HMASTLOCKS = lock;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        bus_idle();
        HADDRS = 32'h0BAD_F00D;
        HRESPM = 1'b1;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", HREADYOUTS); end
        n_cmp++; if (HRESPS !== 1'b0) begin n_err++; $display("FAIL rst_resp got=%b exp=0", HRESPS); end
        n_cmp++; if (held_tran_op !== 1'b0) begin n_err++; $display("FAIL rst_tran got=%b exp=0", held_tran_op); end
        n_cmp++; if (addr_op !== 32'h0BAD_F00D) begin n_err++; $display("FAIL rst_addr got=%h exp=0badf00d", addr_op); end
        HRESPM = 1'b0;
        // Park a held transfer, then reset while it is waiting.
        bus_addr(2'b10, 32'h4000_0010, 1'b0, 3'd0, 1'b0);
        active_op = 1'b0; HREADYMUXM = 1'b1;
        #1;
        n_cmp++; if (held_tran_op !== 1'b1) begin n_err++; $display("FAIL rst_pre_tran got=%b exp=1", held_tran_op); end
        tick();
        bus_idle();
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL rst_wait_ready got=%b exp=0", HREADYOUTS); end
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
        HADDRS = 32'h5555_0000;
        HREADYMUXM = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL rst_after_ready got=%b exp=1", HREADYOUTS); end
        n_cmp++; if (held_tran_op !== 1'b0) begin n_err++; $display("FAIL rst_after_tran got=%b exp=0", held_tran_op); end
        n_cmp++; if (addr_op !== 32'h5555_0000) begin n_err++; $display("FAIL rst_after_addr got=%h exp=55550000", addr_op); end
        HREADYMUXM = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_pass_through();
        bus_addr(2'b10, 32'h1000_0040, 1'b1, 3'd0, 1'b0);
        active_op = 1'b1; HREADYMUXM = 1'b1;
        #1;
        n_cmp++; if (addr_op !== 32'h1000_0040) begin n_err++; $display("FAIL pt_addr got=%h exp=10000040", addr_op); end
        n_cmp++; if (write_op !== 1'b1) begin n_err++; $display("FAIL pt_write got=%b exp=1", write_op); end
        n_cmp++; if (held_tran_op !== 1'b1) begin n_err++; $display("FAIL pt_tran got=%b exp=1", held_tran_op); end
        tick();
        bus_idle();
        HWDATAS = 32'hA5A5_1234; HREADYMUXM = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL pt_ready0 got=%b exp=0", HREADYOUTS); end
        n_cmp++; if (wdata_op !== 32'hA5A5_1234) begin n_err++; $display("FAIL pt_wdata got=%h exp=a5a51234", wdata_op); end
        tick();
        HREADYMUXM = 1'b1;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL pt_ready1 got=%b exp=1", HREADYOUTS); end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_held();
        bus_addr(2'b10, 32'h2000_0000, 1'b0, 3'd0, 1'b0);
        active_op = 1'b0; HREADYMUXM = 1'b1;
        #1;
        n_cmp++; if (held_tran_op !== 1'b1) begin n_err++; $display("FAIL held_acc_tran got=%b exp=1", held_tran_op); end
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL held_acc_ready got=%b exp=1", HREADYOUTS); end
        tick();
        // Next master address sits on the bus while stalled; the held one must win.
        bus_addr(2'b10, 32'hDEAD_0000, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL held_wait_ready[%0d] got=%b exp=0", i, HREADYOUTS); end
            n_cmp++; if (addr_op !== 32'h2000_0000) begin n_err++; $display("FAIL held_wait_addr[%0d] got=%h exp=20000000", i, addr_op); end
            n_cmp++; if (write_op !== 1'b0) begin n_err++; $display("FAIL held_wait_write[%0d] got=%b exp=0", i, write_op); end
            n_cmp++; if (held_tran_op !== 1'b1) begin n_err++; $display("FAIL held_wait_tran[%0d] got=%b exp=1", i, held_tran_op); end
            tick();
        end
        active_op = 1'b1;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL held_issue_ready got=%b exp=0", HREADYOUTS); end
        n_cmp++; if (addr_op !== 32'h2000_0000) begin n_err++; $display("FAIL held_issue_addr got=%h exp=20000000", addr_op); end
        tick();
        bus_idle();
        HREADYMUXM = 1'b0; HRDATAM = 32'h1234_5678;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL held_data_ready0 got=%b exp=0", HREADYOUTS); end
        n_cmp++; if (held_tran_op !== 1'b0) begin n_err++; $display("FAIL held_data_tran got=%b exp=0", held_tran_op); end
        n_cmp++; if (HRDATAS !== 32'h1234_5678) begin n_err++; $display("FAIL held_rdata0 got=%h exp=12345678", HRDATAS); end
        tick();
        HREADYMUXM = 1'b1; HRDATAM = 32'hCAFE_BABE;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL held_data_ready1 got=%b exp=1", HREADYOUTS); end
        n_cmp++; if (HRDATAS !== 32'hCAFE_BABE) begin n_err++; $display("FAIL held_rdata1 got=%h exp=cafebabe", HRDATAS); end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_burst();
        logic [1:0]  tr  [6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        logic [31:0] ad  [6] = '{32'h3000_0000, 32'h3000_0004, 32'h3000_0008,
                                 32'h3000_0008, 32'h3000_000C, 32'h3000_000C};
        logic        mx  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        tv  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        active_op = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_addr(tr[i], ad[i], 1'b1, 3'd3, 1'b0);
            HREADYMUXM = mx[i];
            #1;
            n_cmp++; if (HREADYOUTS !== rdy[i]) begin n_err++; $display("FAIL burst_ready[%0d] got=%b exp=%b", i, HREADYOUTS, rdy[i]); end
            n_cmp++; if (held_tran_op !== tv[i]) begin n_err++; $display("FAIL burst_tran[%0d] got=%b exp=%b", i, held_tran_op, tv[i]); end
            if (tv[i]) begin
                n_cmp++; if (addr_op !== ad[i]) begin n_err++; $display("FAIL burst_addr[%0d] got=%h exp=%h", i, addr_op, ad[i]); end
            end
            tick();
        end
        bus_idle();
        HREADYMUXM = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL burst_end_ready got=%b exp=1", HREADYOUTS); end
        HREADYMUXM = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_error();
        bus_addr(2'b10, 32'h5000_0000, 1'b1, 3'd0, 1'b0);
        active_op = 1'b1; HREADYMUXM = 1'b1; HRESPM = 1'b0;
        #1;
        n_cmp++; if (held_tran_op !== 1'b1) begin n_err++; $display("FAIL err_tran got=%b exp=1", held_tran_op); end
        tick();
        bus_idle();
        HREADYMUXM = 1'b0; HRESPM = 1'b1;
        #1;
        n_cmp++; if (HRESPS !== 1'b1) begin n_err++; $display("FAIL err_resp1 got=%b exp=1", HRESPS); end
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL err_ready1 got=%b exp=0", HREADYOUTS); end
        tick();
        HREADYMUXM = 1'b1;
        #1;
        n_cmp++; if (HRESPS !== 1'b1) begin n_err++; $display("FAIL err_resp2 got=%b exp=1", HRESPS); end
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL err_ready2 got=%b exp=1", HREADYOUTS); end
        tick();
        HREADYMUXM = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL err_idle_ready got=%b exp=1", HREADYOUTS); end
        n_cmp++; if (HRESPS !== 1'b0) begin n_err++; $display("FAIL err_idle_resp got=%b exp=0", HRESPS); end
        HRESPM = 1'b0; HREADYMUXM = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_lock();
        bus_addr(2'b10, 32'h6000_0100, 1'b0, 3'd0, 1'b1);
        active_op = 1'b0; HREADYMUXM = 1'b1;
        #1;
        n_cmp++; if (mastlock_op !== 1'b1) begin n_err++; $display("FAIL lock_acc got=%b exp=1", mastlock_op); end
        tick();
        HSELS = 1'b0; HMASTLOCKS = 1'b0; HTRANSS = 2'b00;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (mastlock_op !== 1'b1) begin n_err++; $display("FAIL lock_hold[%0d] got=%b exp=1", i, mastlock_op); end
            n_cmp++; if (sel_op !== 1'b1) begin n_err++; $display("FAIL lock_sel[%0d] got=%b exp=1", i, sel_op); end
            n_cmp++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL lock_ready[%0d] got=%b exp=0", i, HREADYOUTS); end
            tick();
        end
        active_op = 1'b1;
        #1;
        n_cmp++; if (mastlock_op !== 1'b1) begin n_err++; $display("FAIL lock_issue got=%b exp=1", mastlock_op); end
        n_cmp++; if (held_tran_op !== 1'b1) begin n_err++; $display("FAIL lock_issue_tran got=%b exp=1", held_tran_op); end
        tick();
        bus_idle();
        active_op = 1'b0;
        #1;
        n_cmp++; if (mastlock_op !== 1'b0) begin n_err++; $display("FAIL lock_release got=%b exp=0", mastlock_op); end
        tick();
    endtask

    // ------------------------------------------------------------------
    // Random traffic. The model tracks, in bus terms, whether a transfer is
    // parked waiting for the output stage and whether this port owns a data
    // phase; accepted address phases are queued and must leave in order.
    task automatic test_random();
        logic m_pend = 1'b0;
        logic m_data = 1'b0;
        logic m_ready_last = 1'b1;
        ap_t  m_hold = '0;
        ap_t  live;
        ap_t  exp_ap;
        ap_t  dut_ap;
        ap_t  e;
        ap_t  sb[$];
        logic exp_ready, exp_resp, acc, exp_tran, issued;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (m_ready_last) begin
                HSELS      = ($urandom_range(0, 3) != 0);
                HTRANSS    = 2'($urandom_range(0, 3));
                HADDRS     = $urandom & 32'hFFFF_FFFC;
                HWRITES    = 1'($urandom_range(0, 1));
                HSIZES     = 3'($urandom_range(0, 2));
                HBURSTS    = 3'($urandom_range(0, 7));
                HPROTS     = 4'($urandom_range(0, 15));
                HMASTERS   = 4'($urandom_range(0, 15));
                HMASTLOCKS = 1'($urandom_range(0, 1));
            end
            active_op  = 1'($urandom_range(0, 1));
            HREADYMUXM = ($urandom_range(0, 3) != 0);
            HRESPM     = ($urandom_range(0, 7) == 0);
            HRDATAM    = $urandom;
            HWDATAS    = $urandom;
            HRESET     = ($urandom_range(0, 63) == 0);
            #1;
            live      = {HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS, HMASTLOCKS};
            exp_ready = m_pend ? 1'b0 : (m_data ? HREADYMUXM : 1'b1);
            exp_resp  = (!m_pend && m_data) ? HRESPM : 1'b0;
            acc       = HSELS & exp_ready & HTRANSS[1];
            exp_tran  = m_pend | acc;
            exp_ap    = m_pend ? m_hold : live;
            issued    = exp_tran & active_op & HREADYMUXM;
            dut_ap    = {sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op, master_op, mastlock_op};
            n_cmp++; if (HREADYOUTS !== exp_ready) begin n_err++; $display("FAIL rnd_ready c%0d got=%b exp=%b", cyc, HREADYOUTS, exp_ready); end
            n_cmp++; if (HRESPS !== exp_resp) begin n_err++; $display("FAIL rnd_resp c%0d got=%b exp=%b", cyc, HRESPS, exp_resp); end
            n_cmp++; if (held_tran_op !== exp_tran) begin n_err++; $display("FAIL rnd_tran c%0d got=%b exp=%b", cyc, held_tran_op, exp_tran); end
            n_cmp++; if (dut_ap !== exp_ap) begin n_err++; $display("FAIL rnd_ap c%0d got=%h exp=%h", cyc, dut_ap, exp_ap); end
            n_cmp++; if (HRDATAS !== HRDATAM) begin n_err++; $display("FAIL rnd_rdata c%0d got=%h exp=%h", cyc, HRDATAS, HRDATAM); end
            n_cmp++; if (wdata_op !== HWDATAS) begin n_err++; $display("FAIL rnd_wdata c%0d got=%h exp=%h", cyc, wdata_op, HWDATAS); end
            if (exp_ready && acc) sb.push_back(live);
            if (issued) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rnd_order c%0d got=%h exp=<none queued>", cyc, dut_ap);
                end else begin
                    e = sb.pop_front();
                    if (dut_ap !== e) begin n_err++; $display("FAIL rnd_order c%0d got=%h exp=%h", cyc, dut_ap, e); end
                end
            end
            if (HRESET) begin
                m_pend = 1'b0; m_data = 1'b0; sb.delete();
            end else if (m_pend) begin
                if (issued) begin m_pend = 1'b0; m_data = 1'b1; end
            end else if (exp_ready) begin
                if (acc && issued) begin
                    m_data = 1'b1;
                end else if (acc) begin
                    m_pend = 1'b1; m_hold = live; m_data = 1'b0;
                end else begin
                    m_data = 1'b0;
                end
            end
            m_ready_last = exp_ready;
            tick();
        end
        HRESET = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1;
        bus_idle();
        active_op  = 1'b0;
        HREADYMUXM = 1'b1;
        HRESPM     = 1'b0;
        HRDATAM    = 32'h0;
        HWDATAS    = 32'h0;
        tick();
        tick();
        HRESET = 1'b0;
        test_reset();
        test_pass_through();
        test_held();
        test_burst();
        test_error();
        test_lock();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
